// File: rtl/rst_sequencer_if.sv
// Reset-sequencer bus: software/watchdog requests in, per-domain resets and status out.
`timescale 1ns/1ps
interface rst_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              sw_rst_req;
  logic              wdt_kick;
  logic [NUM_CH-1:0] rst_n_out;
  logic              rst_done;
  logic [1:0]        rst_cause;

  modport master (output sw_rst_req, wdt_kick, input rst_n_out, rst_done, rst_cause);
  modport slave  (input sw_rst_req, wdt_kick, output rst_n_out, rst_done, rst_cause);
endinterface

// File: rtl/rst_sequencer.sv
// Staggered multi-channel reset sequencer with software reset and cause capture.
// Define RST_SEQ_WDT_EN to add the watchdog that forces a reset when not kicked.
`timescale 1ns/1ps
module rst_sequencer #(
  parameter int              NUM_CH         = 4,
  parameter int              HOLD_CYCLES    = 16,
  parameter int              STAGGER_CYCLES = 8,
  parameter longint unsigned WDT_CYCLES     = 64'd1000000
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  rst_sequencer_if.slave bus
);
  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);
  localparam logic [31:0]      WDT_LAST  = 32'(WDT_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, STAGGER, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, nxt_idx;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic [1:0]        sync_q;
  logic              srst_n;
  logic              wdt_expire;
  logic              req_any;

  // Board reset: asynchronous assert, release synchronised through two flops
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) sync_q <= 2'b00;
    else             sync_q <= {sync_q[0], 1'b1};
  end
  assign srst_n = sync_q[1];

`ifdef RST_SEQ_WDT_EN
  logic [31:0] wdt_q;

  // A kick on the expiry edge wins, so expiry is gated by the kick itself
  assign wdt_expire = (state_q == DONE) && (wdt_q == WDT_LAST) && !bus.wdt_kick;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)                                        wdt_q <= '0;
    else if (state_q != DONE || bus.wdt_kick || req_any)    wdt_q <= '0;
    else                                                    wdt_q <= wdt_q + 32'd1;
  end
`else
  wire unused_ok = ^{bus.wdt_kick, WDT_LAST};
  assign wdt_expire = 1'b0;
`endif

  assign req_any = srst_n && (bus.sw_rst_req || wdt_expire);
  assign nxt_idx = idx_q + IDX_W'(1);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (req_any) begin
      // Software request takes precedence over a coincident watchdog expiry
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      cause_d = bus.sw_rst_req ? 2'b01 : 2'b10;
    end else begin
      case (state_q)
        HOLD: begin
          if (srst_n) begin
            if (cnt_q == HOLD_LAST) begin
              cnt_d      = '0;
              rst_n_d[0] = 1'b1;
              if (NUM_CH == 1) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = STAGGER;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        STAGGER: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d            = '0;
            idx_d            = nxt_idx;
            rst_n_d[nxt_idx] = 1'b1;
            if (nxt_idx == LAST_CH) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.rst_done  = done_q;
  assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: vector table for power-on / request sequences plus
// hand-written async-reset and watchdog corner cases.
`timescale 1ns/1ps
module tb_rst_sequencer;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rst_sequencer_if #(.NUM_CH(4)) bus0 ();
  rst_sequencer_if #(.NUM_CH(1)) bus1 ();

  rst_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8), .WDT_CYCLES(64'd100)) dut0 (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .bus       (bus0)
  );

  rst_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .WDT_CYCLES(64'd1000000)) dut1 (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .bus       (bus1)
  );

  typedef struct {
    int         adv;
    logic       sw;
    logic [3:0] rst;
    logic       done;
    logic [1:0] cause;
    logic       rst1;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add_vec(input int adv, input logic sw, input logic [3:0] rst,
                         input logic done, input logic [1:0] cause, input logic rst1);
    vec_t v;
    v.adv = adv; v.sw = sw; v.rst = rst; v.done = done; v.cause = cause; v.rst1 = rst1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string name, input logic [3:0] rst, input logic done,
                          input logic [1:0] cause);
    chk({name, " rst_n_out"}, 32'(bus0.rst_n_out), 32'(rst));
    chk({name, " rst_done"},  32'(bus0.rst_done),  32'(done));
    chk({name, " rst_cause"}, 32'(bus0.rst_cause), 32'(cause));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus0.sw_rst_req = vecs[i].sw;
      repeat (vecs[i].adv) tick();
      bus0.sw_rst_req = 1'b0;
      chk_main($sformatf("vec%0d", i), vecs[i].rst, vecs[i].done, vecs[i].cause);
      chk($sformatf("vec%0d ch1 rst_n_out", i), 32'(bus1.rst_n_out), 32'(vecs[i].rst1));
      chk($sformatf("vec%0d ch1 rst_done", i),  32'(bus1.rst_done),  32'(vecs[i].rst1));
    end
  endtask

  initial begin
    // Power-on: edges counted from E1, the first edge with CPU_RESETN high
    add_vec( 2, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0); // E2
    add_vec( 1, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1); // E3: single-channel instance done
    add_vec(14, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1); // E17
    add_vec( 1, 1'b0, 4'b0001, 1'b0, 2'b00, 1'b1); // E18
    add_vec( 7, 1'b0, 4'b0001, 1'b0, 2'b00, 1'b1); // E25
    add_vec( 1, 1'b0, 4'b0011, 1'b0, 2'b00, 1'b1); // E26
    add_vec( 7, 1'b0, 4'b0011, 1'b0, 2'b00, 1'b1); // E33
    add_vec( 1, 1'b0, 4'b0111, 1'b0, 2'b00, 1'b1); // E34
    add_vec( 7, 1'b0, 4'b0111, 1'b0, 2'b00, 1'b1); // E41
    add_vec( 1, 1'b0, 4'b1111, 1'b1, 2'b00, 1'b1); // E42
    // One-cycle software request at N after completion
    add_vec( 5, 1'b0, 4'b1111, 1'b1, 2'b00, 1'b1);
    add_vec( 1, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b1); // N
    add_vec(15, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b1); // N+15
    add_vec( 1, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1); // N+16
    add_vec(23, 1'b0, 4'b0111, 1'b0, 2'b01, 1'b1); // N+39
    add_vec( 1, 1'b0, 4'b1111, 1'b1, 2'b01, 1'b1); // N+40
    // Request held for three edges, last one at R
    add_vec( 3, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b1);
    add_vec(15, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b1); // R+15
    add_vec( 1, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1); // R+16
    add_vec(11, 1'b0, 4'b0011, 1'b0, 2'b01, 1'b1); // R+27
    // Mid-sequence request at M with ch0/ch1 released
    add_vec( 1, 1'b1, 4'b0000, 1'b0, 2'b01, 1'b1); // M
    add_vec(15, 1'b0, 4'b0000, 1'b0, 2'b01, 1'b1); // M+15
    add_vec( 1, 1'b0, 4'b0001, 1'b0, 2'b01, 1'b1); // M+16
    add_vec(24, 1'b0, 4'b1111, 1'b1, 2'b01, 1'b1); // M+40

    bus0.sw_rst_req = 1'b0;
    bus0.wdt_kick   = 1'b0;
    bus1.sw_rst_req = 1'b0;
    bus1.wdt_kick   = 1'b1;

    repeat (10) tick();
    chk_main("in_reset", 4'b0000, 1'b0, 2'b00);
    chk("in_reset ch1 rst_n_out", 32'(bus1.rst_n_out), 32'd0);

    rstn = 1'b1;
    run_vecs(0, 23);

    // Asynchronous pin reset while in DONE, checked between clock edges
    rstn = 1'b0;
    #2;
    chk_main("async_rst", 4'b0000, 1'b0, 2'b00);
    chk("async_rst ch1 rst_n_out", 32'(bus1.rst_n_out), 32'd0);
    chk("async_rst ch1 rst_done",  32'(bus1.rst_done),  32'd0);
    #100000;
    tick();
    chk_main("async_rst_held", 4'b0000, 1'b0, 2'b00);
    rstn = 1'b1;
    run_vecs(0, 9);

`ifdef RST_SEQ_WDT_EN
    // Unkicked watchdog expires 100 edges after rst_done
    repeat (99) tick();
    chk_main("wdt_pre", 4'b1111, 1'b1, 2'b00);
    tick();
    chk_main("wdt_fire", 4'b0000, 1'b0, 2'b10);
    repeat (40) tick();
    chk_main("wdt_reseq", 4'b1111, 1'b1, 2'b10);
    for (int i = 0; i < 20; i++) begin
      bus0.wdt_kick = 1'b1;
      tick();
      bus0.wdt_kick = 1'b0;
      repeat (49) tick();
      chk_main($sformatf("wdt_kicked%0d", i), 4'b1111, 1'b1, 2'b10);
    end
    // Software request on the expiry edge reports software cause
    repeat (50) tick();
    chk_main("wdt_sw_pre", 4'b1111, 1'b1, 2'b10);
    bus0.sw_rst_req = 1'b1;
    tick();
    bus0.sw_rst_req = 1'b0;
    chk_main("wdt_sw_same", 4'b0000, 1'b0, 2'b01);
    repeat (40) tick();
    chk_main("wdt_sw_reseq", 4'b1111, 1'b1, 2'b01);
    // Kick on the expiry edge suppresses the reset
    repeat (99) tick();
    bus0.wdt_kick = 1'b1;
    tick();
    bus0.wdt_kick = 1'b0;
    chk_main("wdt_kick_wins", 4'b1111, 1'b1, 2'b01);
    repeat (99) tick();
    chk_main("wdt_kick_pre2", 4'b1111, 1'b1, 2'b01);
    tick();
    chk_main("wdt_fire2", 4'b0000, 1'b0, 2'b10);
`else
    repeat (200) tick();
    chk_main("no_wdt", 4'b1111, 1'b1, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer between the board reset pin and the `Computer` core. It replaces the single board reset pulse with a synchronised, multi-channel reset:
- holds every reset domain low for a programmable time;
- releases the domains one at a time (CPU, memory, UART and so on) in a staggered order;
- accepts software reset requests and, optionally, watchdog resets;
- records what caused the last reset.

## Interface
- `NUM_CH`, 4: number of reset channels, legal range 1..16; channel 0 releases first.
- `HOLD_CYCLES`, 16: cycles all channels stay low after the synchronised reset release or after a reset request; must be ≥1.
- `STAGGER_CYCLES`, 8: cycles between consecutive channel releases; must be ≥1.
- `WDT_CYCLES`, 1000000: watchdog timeout in cycles, at most 2^32; used only with `RST_SEQ_WDT_EN`.
- `CLK100MHZ`  in  1  system clock; the block has one clock.
- `CPU_RESETN`  in  1  board reset; asynchronous assert, active-low.
- `sw_rst_req`  in  1  software reset request, sampled high on any rising edge.
- `wdt_kick`  in  1  watchdog service pulse.
- `rst_n_out`  out  NUM_CH  active-low reset per domain, driven directly from flops.
- `rst_done`  out  1  high when every channel is released.
- `rst_cause`  out  2  cause of the last reset: 00 = POR/pin, 01 = SW, 10 = WDT, 11 = reserved.

## Operation
- Internal synchroniser: a two-flop chain, cleared asynchronously by `CPU_RESETN` low and shifting in 1 each edge. Its output is `srst_n`.
- FSM states: HOLD, STAGGER, DONE.
- While `CPU_RESETN` is low:
  - all outputs are 0, `rst_cause`=00;
  - FSM is in HOLD with counter=0 and channel index=0;
  - watchdog counter is 0.
- HOLD:
  - the counter advances one per edge while `srst_n`=1;
  - on the edge where counter == `HOLD_CYCLES`-1, `rst_n_out[0]` goes to 1, the counter is cleared, and the FSM moves to STAGGER (or to DONE when `NUM_CH`=1).
- STAGGER:
  - the counter advances each edge;
  - on the edge where counter == `STAGGER_CYCLES`-1, the next channel goes to 1 and the index increments;
  - the edge that releases channel `NUM_CH`-1 also sets `rst_done`=1 and moves the FSM to DONE.
- Reset request (`sw_rst_req`=1 on an edge, in any state with `srst_n`=1):
  - on that same edge all `rst_n_out` go to 0 and `rst_done` goes to 0;
  - `rst_cause` becomes 01, the counter and index clear, and the FSM enters HOLD;
  - a request arriving mid-sequence restarts the full sequence;
  - a request held high for several cycles keeps the block in HOLD with counter 0.
- Released channels never re-assert except through a reset request or `CPU_RESETN`.
- `rst_cause` holds its value until the next reset event.
- `CPU_RESETN` asserted mid-sequence or in DONE clears everything asynchronously and sets `rst_cause`=00.

## Timing
- Let E1 be the first rising edge with `CPU_RESETN` high. `srst_n` rises at E2.
- Channel k rises at edge E2 + `HOLD_CYCLES` + k·`STAGGER_CYCLES`.
- `rst_done` rises on the same edge as channel `NUM_CH`-1.
- After a reset request sampled at edge N: outputs go low at N, and channel k rises at N + `HOLD_CYCLES` + k·`STAGGER_CYCLES`.
- Counter width is ceil(log2(max(`HOLD_CYCLES`, `STAGGER_CYCLES`))) + 1 bits; it never wraps.
- Every output is a flop output; no combinational path from inputs to outputs.

## Configuration
- Macro `RST_SEQ_WDT_EN` defined:
  - a 32-bit watchdog counter runs only in DONE and clears on any edge with `wdt_kick`=1;
  - when it reaches `WDT_CYCLES`-1 without a kick, it triggers a reset exactly like `sw_rst_req`, with `rst_cause`=10;
  - if a kick and expiry fall on the same edge, the kick wins and no reset occurs;
  - if `sw_rst_req` and expiry fall on the same edge, cause is 01.
- Macro not defined: no watchdog logic, `wdt_kick` is ignored, and `rst_cause` is never 10.

## Test plan
- Defaults; `CPU_RESETN` low for 100 ns, then high -> `rst_n_out` steps 0001 @E18, 0011 @E26, 0111 @E34, 1111 and `rst_done`=1 @E42; `rst_cause`=00.
- Sequence complete; one-cycle `sw_rst_req` at edge N -> `rst_n_out`=0000 at N, `rst_cause`=01, ch0 @N+16, `rst_done` @N+40.
- `sw_rst_req` at edge E30 (ch0 and ch1 already released) -> all low at E30, restart, ch0 @E46; no channel releases early.
- `CPU_RESETN` pulsed low for 100 µs while in DONE -> outputs 0 with no clock edge needed, `rst_cause`=00, full sequence repeats after release.
- With `RST_SEQ_WDT_EN` and `WDT_CYCLES`=100: no kicks -> reset 100 cycles after `rst_done`, `rst_cause`=10; kick every 50 cycles -> no reset over 1000 cycles.
- `NUM_CH`=1, `HOLD_CYCLES`=1 -> `rst_n_out` and `rst_done` both rise @E3.
